// File: rtl/vsa_core_param.sv
// rtl/vsa_core_param.sv - parametrised multi-cycle VSA core with req/ack instruction and data memory handshakes
// Define VSA_HALT_EN to make opcode 7 stop the core in HALT; otherwise opcode 7 is a NOP.
module vsa_core_param #(
    parameter int DW  = 8,
    parameter int RAW = 2,
    parameter int PCW = 5,
    localparam int IW   = 6 + 3 * RAW,
    localparam int IMMW = RAW + 3,
    localparam int NREG = 2 ** RAW
) (
    input  logic           clock,
    input  logic           reset_n,
    output logic [PCW-1:0] pc,
    output logic           imem_req,
    input  logic           imem_ack,
    input  logic [IW-1:0]  instruction,
    output logic [DW-1:0]  daddr,
    output logic [DW-1:0]  dataout,
    input  logic [DW-1:0]  datain,
    output logic           dmem_req,
    input  logic           dmem_ack,
    output logic           wr,
    output logic           halted
);

    localparam logic [2:0] OP_LW   = 3'd0;
    localparam logic [2:0] OP_SW   = 3'd1;
    localparam logic [2:0] OP_BEQZ = 3'd2;
    localparam logic [2:0] OP_ALU  = 3'd3;
    localparam logic [2:0] OP_ADDI = 3'd4;
    localparam logic [2:0] OP_SUBI = 3'd5;
    localparam logic [2:0] OP_BNEZ = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            started;
    logic [IW-1:0]   ir;
    logic [PCW-1:0]  npc;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [DW-1:0]   alu_out;
    logic            cond;
    logic [DW-1:0]   lmd;
    logic [DW-1:0]   regs [NREG];

    logic [2:0]      op;
    logic [RAW-1:0]  s1;
    logic [RAW-1:0]  rf2;
    logic [RAW-1:0]  rd;
    logic [2:0]      fun;
    logic [IMMW-1:0] imm;
    logic [DW-1:0]   imm_dw;
    logic [PCW-1:0]  pc_off;
    logic [PCW-1:0]  target;
    logic [DW-1:0]   alu_res;
    logic            is_mem;
    logic            is_branch;

    assign op        = ir[IW-1 -: 3];
    assign s1        = ir[IW-4 -: RAW];
    assign rf2       = ir[IW-4-RAW -: RAW];
    assign rd        = ir[IW-4-2*RAW -: RAW];
    assign fun       = ir[2:0];
    assign imm       = ir[IMMW-1:0];
    assign imm_dw    = DW'($signed(imm));
    assign pc_off    = PCW'($signed(imm));
    assign target    = npc + pc_off;
    assign is_mem    = (op == OP_LW) || (op == OP_SW);
    assign is_branch = (op == OP_BEQZ) || (op == OP_BNEZ);

    always_comb begin
        alu_res = '0;
        case (fun)
            3'd0: alu_res = a + b;
            3'd1: alu_res = a - b;
            3'd2: alu_res = a & b;
            3'd3: alu_res = a | b;
            3'd4: alu_res = a ^ b;
            3'd5: alu_res = ~a;
            3'd6: alu_res = a >> 1;
            3'd7: alu_res = $unsigned($signed(a) >>> 1);
            default: alu_res = '0;
        endcase
    end

    // started keeps every request low in the first cycle after reset release
    assign imem_req = (state == S_IF) && started;
    assign dmem_req = (state == S_MEM) && is_mem;
    assign wr       = dmem_req && (op == OP_SW);
    assign daddr    = alu_out;
    assign dataout  = b;

`ifdef VSA_HALT_EN
    assign halted = (state == S_HALT);
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IF;
            started <= 1'b0;
        end else begin
            state   <= next_state;
            started <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IF:  if (imem_req && imem_ack) next_state = S_ID;
            S_ID:  next_state = S_EX;
            S_EX: begin
                next_state = S_MEM;
`ifdef VSA_HALT_EN
                if (op == OP_HALT) next_state = S_HALT;
`endif
            end
            S_MEM: if (!is_mem || dmem_ack) next_state = S_WB;
            S_WB:  next_state = S_IF;
            S_HALT: next_state = S_HALT;
            default: next_state = S_IF;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= '0;
            npc     <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            cond    <= 1'b0;
            lmd     <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_IF: begin
                    if (imem_req && imem_ack) begin
                        ir  <= instruction;
                        npc <= pc + PCW'(1);
                    end
                end
                S_ID: begin
                    a <= regs[s1];
                    b <= regs[rf2];
                end
                S_EX: begin
                    case (op)
                        OP_LW, OP_SW, OP_ADDI: alu_out <= a + imm_dw;
                        OP_SUBI:               alu_out <= a - imm_dw;
                        OP_ALU:                alu_out <= alu_res;
                        OP_BEQZ:               cond    <= (a == '0);
                        OP_BNEZ:               cond    <= (a != '0);
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (dmem_req && dmem_ack && (op == OP_LW)) lmd <= datain;
                    if (next_state == S_WB) pc <= (is_branch && cond) ? target : npc;
                end
                S_WB: begin
                    // regs[0] is never written, so R0 reads as zero
                    case (op)
                        OP_ALU:           if (rd != '0)  regs[rd]  <= alu_out;
                        OP_ADDI, OP_SUBI: if (rf2 != '0) regs[rf2] <= alu_out;
                        OP_LW:            if (rf2 != '0) regs[rf2] <= lmd;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
